// File: rtl/pixel_serializer_if.sv
// Batch-in / pixel-out stream bundle between the colour LUT, serializer and display packer.
interface pixel_serializer_if #(
  parameter int unsigned RBG_SIZE    = 24,
  parameter int unsigned NUM_ENGINES = 12
);
  logic [NUM_ENGINES-1:0][RBG_SIZE-1:0] rgb_in;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [RBG_SIZE-1:0]                  out_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_sof;
  logic                                 out_eol;
  logic                                 frame_done;

  // Upstream/downstream environment side
  modport master (
    output rgb_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eol, frame_done
  );

  // Serializer side
  modport slave (
    input  rgb_in, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eol, frame_done
  );
endinterface

// File: rtl/pixel_serializer.sv
// Serializes one batch of NUM_ENGINES parallel pixels into a one-pixel-per-cycle
// raster stream with start-of-frame / end-of-line markers and a frame_done pulse.
module pixel_serializer #(
  parameter int unsigned RBG_SIZE    = 24,
  parameter int unsigned NUM_ENGINES = 12,
  parameter int unsigned IMAGE_W     = 640,
  parameter int unsigned IMAGE_H     = 480
) (
  input logic               clk,
  input logic               reset,
  pixel_serializer_if.slave bus
);

  localparam int unsigned SLOT_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int unsigned X_W    = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
  localparam int unsigned Y_W    = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                               state;
  logic [NUM_ENGINES-1:0][RBG_SIZE-1:0] batch;
  logic [SLOT_W-1:0]                    slot;
  logic [X_W-1:0]                       x;
  logic [Y_W-1:0]                       y;
  logic [RBG_SIZE-1:0]                  data_q;
  logic                                 frame_done_q;

  logic out_valid_c;
  logic out_hs_c;
  logic line_last_c;
  logic frame_last_c;
  logic batch_last_c;
  logic in_ready_c;
  logic in_accept_c;

  // Handshake and position decode from the registered counters
  assign out_valid_c  = (state == DRAIN);
  assign out_hs_c     = out_valid_c && bus.out_ready;
  assign line_last_c  = (x == X_W'(IMAGE_W - 1));
  assign frame_last_c = line_last_c && (y == Y_W'(IMAGE_H - 1));
  // A batch ends at its last slot or at the line end, whichever comes first
  assign batch_last_c = (slot == SLOT_W'(NUM_ENGINES - 1)) || line_last_c;
  // Accept a new batch while idle, or in the same cycle the held batch empties
  assign in_ready_c   = (state == IDLE) || (out_hs_c && batch_last_c);
  assign in_accept_c  = bus.in_valid && in_ready_c;

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = data_q;
  assign bus.out_sof    = out_valid_c && (x == '0) && (y == '0);
  assign bus.out_eol    = out_valid_c && line_last_c;
  assign bus.frame_done = frame_done_q;

  // Batch capture, pixel pointer / raster counters and FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      batch        <= '0;
      slot         <= '0;
      x            <= '0;
      y            <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (out_hs_c) begin
        if (line_last_c) begin
          x    <= '0;
          slot <= '0;
          if (frame_last_c) begin
            y            <= '0;
            frame_done_q <= 1'b1;
          end else begin
            y <= y + Y_W'(1);
          end
        end else begin
          x    <= x + X_W'(1);
          slot <= batch_last_c ? '0 : slot + SLOT_W'(1);
        end
        if (!batch_last_c) begin
          data_q <= batch[slot + SLOT_W'(1)];
        end
      end

      if (in_accept_c) begin
        batch  <= bus.rgb_in;
        data_q <= bus.rgb_in[0];
        state  <= DRAIN;
      end else if (out_hs_c && batch_last_c) begin
        state <= IDLE;
      end
    end
  end

endmodule
